// File: rtl/fir_mc_pkg.sv
// Shared decode constants, FSM state type and arithmetic helpers for the
// multi-channel PCPI FIR accelerator.
package fir_mc_pkg;

  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_FIRMC   = 7'b0000001;

  localparam logic [2:0] F3_LOAD    = 3'b000;
  localparam logic [2:0] F3_PUSH    = 3'b001;
  localparam logic [2:0] F3_CLEAR   = 3'b010;
  localparam logic [2:0] F3_COMPUTE = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) begin
      return 32'h7FFF_FFFF;
    end else if (v < -64'sd2147483648) begin
      return 32'h8000_0000;
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/fir_mc_lane_sum.sv
// Combinational signed sum of LANES coefficient terms, each added or
// subtracted according to its control bit; disabled lanes contribute zero.
module fir_mc_lane_sum #(
  parameter int unsigned LANES             = 8,
  parameter int unsigned WIDTH_COEFFICIENT = 32,
  parameter int unsigned ACC_WIDTH         = 43
) (
  input  logic [LANES*WIDTH_COEFFICIENT-1:0] coef,
  input  logic [LANES-1:0]                   pos,
  input  logic [LANES-1:0]                   en,
  output logic signed [ACC_WIDTH-1:0]        sum
);

  logic signed [ACC_WIDTH-1:0] term;

  always_comb begin
    sum  = '0;
    term = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      term = ACC_WIDTH'($signed(coef[l*WIDTH_COEFFICIENT +: WIDTH_COEFFICIENT]));
      if (en[l]) begin
        sum = pos[l] ? (sum + term) : (sum - term);
      end
    end
  end

endmodule

// File: rtl/pcpi_fir_mc_accel.sv
// PCPI coprocessor: N-channel x K-tap signed coefficient bank with per-channel
// control-bit shift registers; COMPUTE sums +/-h over all taps, LANES per cycle.
module pcpi_fir_mc_accel
  import fir_mc_pkg::*;
#(
  parameter int unsigned N                 = 7,
  parameter int unsigned K                 = 128,
  parameter int unsigned WIDTH_COEFFICIENT = 32,
  parameter int unsigned LANES             = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int unsigned NK        = N * K;
  localparam int unsigned ACC_WIDTH = WIDTH_COEFFICIENT + clog2(NK) + 1;
  localparam int unsigned AW        = (clog2(NK) == 0) ? 1 : clog2(NK);
  localparam int unsigned IDXW      = clog2(NK + LANES) + 1;
  localparam int unsigned WC        = WIDTH_COEFFICIENT;

  logic [WC-1:0]               h_q [NK];
  logic [WC-1:0]               h_d [NK];
  logic [NK-1:0]               sr_q, sr_d;
  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, lane_sum;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [5:0]                  sh_q, sh_d;
  logic [31:0]                 rd_q, rd_d;
  logic                        ack_q, ack_d;

  logic        match, known, accept;
  logic [2:0]  f3;
  logic [31:0] load_addr;
  logic [N-1:0] push_bits;

  assign match = (pcpi_insn[6:0] == OP_CUSTOM0) && (pcpi_insn[31:25] == F7_FIRMC);
  assign f3    = pcpi_insn[14:12];
  assign known = match && (f3 inside {F3_LOAD, F3_PUSH, F3_CLEAR, F3_COMPUTE});
  // resetn gates the combinational accept so wait cannot assert while held in reset
  assign accept = resetn && pcpi_valid && known && !pcpi_ready && (state_q == IDLE);

  assign load_addr = 32'(pcpi_rs1[23:16]) * K + 32'(pcpi_rs1[15:0]);
  assign push_bits = N'(pcpi_rs1);

  // Gather the LANES taps at flat indices idx..idx+LANES-1 (i = n*K + k)
  logic [LANES*WC-1:0] lane_coef;
  logic [LANES-1:0]    lane_pos, lane_en;
  logic [31:0]         flat_i;

  always_comb begin
    lane_coef = '0;
    lane_pos  = '0;
    lane_en   = '0;
    flat_i    = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      flat_i = 32'(idx_q) + l;
      if (flat_i < NK) begin
        lane_coef[l*WC +: WC] = h_q[flat_i[AW-1:0]];
        lane_pos[l]           = sr_q[flat_i[AW-1:0]];
        lane_en[l]            = 1'b1;
      end
    end
  end

  fir_mc_lane_sum #(
    .LANES            (LANES),
    .WIDTH_COEFFICIENT(WC),
    .ACC_WIDTH        (ACC_WIDTH)
  ) u_lane_sum (
    .coef(lane_coef),
    .pos (lane_pos),
    .en  (lane_en),
    .sum (lane_sum)
  );

  logic signed [63:0] acc_ext, shifted;
  logic [31:0]        result;

  always_comb begin
    acc_ext = 64'(acc_q);
    shifted = acc_ext >>> sh_q;
    result  = sat32(shifted);
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    rd_d      = rd_q;
    ack_d     = 1'b0;
    pcpi_wait = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (f3)
            F3_LOAD: begin
              ack_d = 1'b1;
              if ((32'(pcpi_rs1[23:16]) < N) && (32'(pcpi_rs1[15:0]) < K)) begin
                h_d[load_addr[AW-1:0]] = pcpi_rs2[WC-1:0];
              end
            end
            F3_PUSH: begin
              ack_d = 1'b1;
              for (int unsigned n = 0; n < N; n++) begin
                sr_d[n*K +: K] = (sr_q[n*K +: K] << 1) | K'(push_bits[n]);
              end
            end
            F3_CLEAR: begin
              ack_d = 1'b1;
              sr_d  = '0;
            end
            F3_COMPUTE: begin
              pcpi_wait = 1'b1;
              sh_d      = pcpi_rs2[5:0];
              acc_d     = '0;
              idx_d     = '0;
              state_d   = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        pcpi_wait = 1'b1;
        acc_d     = acc_q + lane_sum;
        idx_d     = idx_q + IDXW'(LANES);
        if (32'(idx_q) + LANES >= NK) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rd_d    = result;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      h_q     <= '{default: '0};
      sr_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
    end
  end

  assign pcpi_wr    = (state_q == DONE);
  assign pcpi_ready = ack_q || (state_q == DONE);
  assign pcpi_rd    = (state_q == DONE) ? result : rd_q;

  logic unused_bits;
  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs1, pcpi_rs2, load_addr};

endmodule

// File: tb/tb_pcpi_fir_mc_accel.sv
// Directed self-checking bench for pcpi_fir_mc_accel in its default
// configuration (N=7, K=128, 32-bit coefficients, 8 lanes, 113-cycle COMPUTE).
module tb_pcpi_fir_mc_accel;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [2:0] LOAD    = 3'b000;
  localparam logic [2:0] PUSH    = 3'b001;
  localparam logic [2:0] CLEAR   = 3'b010;
  localparam logic [2:0] COMPUTE = 3'b011;

  pcpi_fir_mc_accel #(
    .N                (7),
    .K                (128),
    .WIDTH_COEFFICIENT(32),
    .LANES            (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_rs1  (pcpi_rs1),
    .pcpi_rs2  (pcpi_rs2),
    .pcpi_wr   (pcpi_wr),
    .pcpi_rd   (pcpi_rd),
    .pcpi_wait (pcpi_wait),
    .pcpi_ready(pcpi_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'd0, f3, 5'd0, 7'b0001011};
  endfunction

  // Single-cycle instruction: expect ready with wr low within a few cycles
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int unsigned cyc;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h01, f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    cyc = 0;
    while (cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pcpi_ready) break;
    end
    check_eq("ack_ready", 32'(pcpi_ready), 32'd1);
    check_eq("ack_wr", 32'(pcpi_wr), 32'd0);
    pcpi_valid = 1'b0;
  endtask

  task automatic compute(input logic [5:0] sh, output logic [31:0] rd, output int lat, output logic wr);
    @(posedge clk);
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h01, COMPUTE);
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = {26'd0, sh};
    #1;
    check_eq("wait_on_accept", 32'(pcpi_wait), 32'd1);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (pcpi_ready) break;
    end
    rd = pcpi_rd;
    wr = pcpi_wr;
    pcpi_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_pulse", {30'd0, pcpi_ready, pcpi_wr}, 32'd0);
    check_eq("rd_hold", pcpi_rd, rd);
  endtask

  task automatic run_check(input string tag, input logic [5:0] sh, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    logic        wr;
    compute(sh, rd, lat, wr);
    check_eq({tag, "_rd"}, rd, exp);
    check_eq({tag, "_wr"}, 32'(wr), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'd113);
  endtask

  task automatic hold_silent(input logic [31:0] ins, input string tag);
    logic any;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = ins;
    pcpi_rs1   = 32'h0000_0001;
    pcpi_rs2   = 32'h0000_0001;
    #1;
    any = pcpi_wait | pcpi_ready | pcpi_wr;
    repeat (20) begin
      @(posedge clk);
      #1;
      any = any | pcpi_wait | pcpi_ready | pcpi_wr;
    end
    check_eq(tag, 32'(any), 32'd0);
    pcpi_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr", 32'(pcpi_wr), 32'd0);
    check_eq("rst_rd", pcpi_rd, 32'd0);
    check_eq("rst_wait", 32'(pcpi_wait), 32'd0);
    check_eq("rst_ready", 32'(pcpi_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_check("zero", 6'd0, 32'h0000_0000);

    // +5 on ch0 (bit 1), -(-3) on ch1 (bit 0)
    issue(LOAD, 32'h0000_0000, 32'd5);
    issue(LOAD, 32'h0001_0000, 32'hFFFF_FFFD);
    issue(PUSH, 32'h0000_0001, 32'd0);
    run_check("pm", 6'd0, 32'd8);

    for (int n = 0; n < 7; n++) begin
      for (int k = 0; k < 128; k++) begin
        issue(LOAD, {8'd0, 8'(n), 16'(k)}, 32'h7FFF_FFFF);
      end
    end
    repeat (128) issue(PUSH, 32'h0000_007F, 32'd0);
    run_check("sat_pos", 6'd0, 32'h7FFF_FFFF);
    run_check("sh31", 6'd31, 32'd895);
    issue(CLEAR, 32'd0, 32'd0);
    run_check("sat_neg", 6'd0, 32'h8000_0000);

    pulse_reset();
    issue(LOAD, 32'h0000_007F, 32'd7);
    issue(CLEAR, 32'd0, 32'd0);
    issue(PUSH, 32'h0000_0001, 32'd0);
    repeat (127) issue(PUSH, 32'h0000_0000, 32'd0);
    run_check("wrap_in", 6'd0, 32'd7);
    issue(PUSH, 32'h0000_0000, 32'd0);
    run_check("wrap_out", 6'd0, 32'hFFFF_FFF9);

    hold_silent(mk_insn(7'h00, COMPUTE), "silent_f7");
    hold_silent(mk_insn(7'h01, 3'b111), "silent_f3");

    issue(LOAD, 32'h0007_0000, 32'd100);
    issue(LOAD, 32'h0000_0080, 32'd100);
    run_check("oob", 6'd0, 32'hFFFF_FFF9);

    // Abort a COMPUTE 50 cycles after accept
    @(posedge clk);
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h01, COMPUTE);
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    repeat (50) @(posedge clk);
    #1;
    check_eq("run_wait", 32'(pcpi_wait), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("abort_wait", 32'(pcpi_wait), 32'd0);
    check_eq("abort_ready", 32'(pcpi_ready), 32'd0);
    check_eq("abort_wr", 32'(pcpi_wr), 32'd0);
    check_eq("abort_rd", pcpi_rd, 32'd0);
    pcpi_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    any = 1'b0;
    repeat (130) begin
      @(posedge clk);
      #1;
      any = any | pcpi_ready | pcpi_wr;
    end
    check_eq("no_late_ready", 32'(any), 32'd0);
    run_check("after_rst", 6'd0, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
